ex_m_skid_stage: RTL



---
 rtl/ex_m_skid_stage_pkg.sv | 24 ++
 rtl/ex_m_skid_stage_entry_reg.sv | 36 +++
 rtl/ex_m_skid_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ex_m_skid_stage_pkg.sv
// rtl/ex_m_skid_stage_pkg.sv - shared widths and payload type for the pipeline stage registers
package ex_m_skid_stage_pkg;

  localparam int CTRL_WIDTH = 7;
  localparam int DST_WIDTH  = 3;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DST_WIDTH-1:0]  dst;
    logic [DATA_WIDTH-1:0] result;
  } stage_payload_t;

  function automatic stage_payload_t pack_payload(input logic [CTRL_WIDTH-1:0] ctrl,
                                                  input logic [DST_WIDTH-1:0]  dst,
                                                  input logic [DATA_WIDTH-1:0] result);
    stage_payload_t p;
    p.ctrl   = ctrl;
    p.dst    = dst;
    p.result = result;
    return p;
  endfunction

endpackage

// File: rtl/ex_m_skid_stage_entry_reg.sv
// rtl/ex_m_skid_stage_entry_reg.sv - payload register with async reset, sync clear and load enable
module stage_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Clear wins over load so a flush kills whatever would have been captured.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_m_skid_stage.sv
// rtl/ex_m_skid_stage.sv - EX->MEM stage register with valid/ready backpressure and optional skid entry
module ex_m_skid_stage
  import ex_m_skid_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH,
  parameter int DST_W  = DST_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [DATA_W-1:0] in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_dst,
  output logic [DATA_W-1:0] out_result,
  output logic [1:0]        occupancy
);

  localparam int PW = CTRL_W + DST_W + DATA_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_q;
  logic [PW-1:0] main_d;
  logic [PW-1:0] skid_q;
  logic          main_valid_q;
  logic          main_valid_d;
  logic          main_load;
  logic          skid_valid_q;
  logic          skid_valid_d;
  logic          skid_load;
  logic          advance;

  assign in_payload = {in_ctrl, in_dst, in_result};

  always_comb begin
    main_load    = 1'b0;
    main_d       = in_payload;
    main_valid_d = main_valid_q;
    skid_load    = 1'b0;
    skid_valid_d = skid_valid_q;
    advance      = ~main_valid_q | out_ready;
    if (SKID != 0) begin
      in_ready = ~skid_valid_q;
      if (advance) begin
        if (skid_valid_q) begin
          // Oldest entry first: skid refills main before any new input.
          main_load    = 1'b1;
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          main_load    = in_valid;
          main_valid_d = in_valid;
        end
      end
      if (in_valid && in_ready && main_valid_q && !out_ready) begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else begin
      in_ready     = advance;
      main_load    = advance;
      main_valid_d = advance ? in_valid : main_valid_q;
    end
  end

  stage_entry_reg #(.W(PW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      stage_entry_reg #(.W(PW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_q)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_valid_q <= 1'b0;
        end else if (flush) begin
          skid_valid_q <= 1'b0;
        end else begin
          skid_valid_q <= skid_valid_d;
        end
      end
    end else begin : g_no_skid
      assign skid_valid_q = 1'b0;
      assign skid_q       = '0;
    end
  endgenerate

  assign out_valid                        = main_valid_q;
  assign {out_ctrl, out_dst, out_result}  = main_q;
  assign occupancy                        = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
